beam_power_writer: RTL

Fills the per-direction power RAM that the downstream max-search block scans. It accepts a stream of beamformed samples, one window of 2^LOG2_WINDOW samples per steering direction, for directions 0..2^ADDR_WIDTH-1 in order. For each window it computes the mean of squared samples and writes it to RAM at that direction's address. When the last address is written it pulses frameDone, which launches the max search (rst/restart of the reader).

---
 rtl/beam_power_writer_pkg.sv | 26 ++
 rtl/beam_power_writer_sat_mean.sv | 21 ++
 rtl/beam_power_writer.sv | 126 ++++++++++++
 3 files changed

// File: rtl/beam_power_writer_pkg.sv
// Shared types and helpers for the beam power writer and the downstream max-search block.
package beam_power_writer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        WRITE,
        DONE
    } state_t;

    // Truncating mean (acc >> log2_window) clamped to the largest positive data_width value.
    // Bit 64 of the result is the saturate flag; callers take the low data_width bits.
    function automatic logic [64:0] sat_mean(input logic [63:0] acc,
                                             input int unsigned log2_window,
                                             input int unsigned data_width);
        logic [63:0] mean;
        logic [63:0] max_val;
        mean    = acc >> log2_window;
        max_val = (64'd1 << (data_width - 1)) - 64'd1;
        if (mean > max_val) begin
            return {1'b1, max_val};
        end
        return {1'b0, mean};
    endfunction

endpackage

// File: rtl/beam_power_writer_sat_mean.sv
// Combinational saturating mean: window accumulator in, clamped RAM word plus saturate flag out.
module power_sat_mean
    import beam_power_writer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned LOG2_WINDOW  = 4
) (
    input  logic [2*SAMPLE_WIDTH+LOG2_WINDOW-1:0] acc,
    output logic [DATA_WIDTH-1:0]                 mean,
    output logic                                  sat
);
    logic [64:0] res;
    logic        unused_res_hi;

    assign res           = sat_mean(64'(acc), LOG2_WINDOW, DATA_WIDTH);
    assign mean          = res[DATA_WIDTH-1:0];
    assign sat           = res[64];
    assign unused_res_hi = ^res[63:DATA_WIDTH];

endmodule

// File: rtl/beam_power_writer.sv
// Per-direction mean-power writer: accumulates one window of squared samples per steering
// direction and writes the saturated mean to the power RAM, then pulses frameDone.
module beam_power_writer
    import beam_power_writer_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 32,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned SAMPLE_WIDTH = 16,
    parameter int unsigned LOG2_WINDOW  = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           sampleValid,
    input  logic signed [SAMPLE_WIDTH-1:0] sample,
    output logic                           sampleReady,
    output logic                           wrEn,
    output logic [ADDR_WIDTH-1:0]          wrAddr,
    output logic signed [DATA_WIDTH-1:0]   wrData,
    output logic                           busy,
    output logic                           frameDone,
    output logic                           overflow
);
    localparam int unsigned SqWidth  = 2 * SAMPLE_WIDTH;
    localparam int unsigned AccWidth = SqWidth + LOG2_WINDOW;

    state_t                 state, state_next;
    logic [AccWidth-1:0]    acc;
    logic [LOG2_WINDOW-1:0] cnt;
    logic [ADDR_WIDTH-1:0]  dir_addr;
    logic [SqWidth-1:0]     sq;
    logic [DATA_WIDTH-1:0]  mean;
    logic                   mean_sat;
    logic                   accept;

    assign accept = sampleValid && sampleReady;
    // Square of a signed value never sets the MSB, so the product is safe to treat as unsigned.
    assign sq     = $unsigned(SqWidth'(sample) * SqWidth'(sample));

    power_sat_mean #(
        .DATA_WIDTH  (DATA_WIDTH),
        .SAMPLE_WIDTH(SAMPLE_WIDTH),
        .LOG2_WINDOW (LOG2_WINDOW)
    ) u_sat_mean (
        .acc (acc),
        .mean(mean),
        .sat (mean_sat)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:  if (start) state_next = ACCUM;
            ACCUM: if (accept && cnt == '1) state_next = WRITE;
            WRITE: state_next = (dir_addr == '1) ? DONE : ACCUM;
            DONE:  state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        sampleReady = 1'b0;
        busy        = 1'b0;
        case (state)
            ACCUM: begin
                sampleReady = 1'b1;
                busy        = 1'b1;
            end
            WRITE, DONE: busy = 1'b1;
            default: ;
        endcase
    end

    // RAM port and status flops; the write strobe lands in the cycle after WRITE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            cnt       <= '0;
            dir_addr  <= '0;
            wrEn      <= 1'b0;
            wrAddr    <= '0;
            wrData    <= '0;
            frameDone <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            wrEn      <= 1'b0;
            frameDone <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        dir_addr <= '0;
                        acc      <= '0;
                        cnt      <= '0;
                        overflow <= 1'b0;
                    end
                end
                ACCUM: begin
                    if (accept) begin
                        acc <= acc + AccWidth'(sq);
                        cnt <= cnt + LOG2_WINDOW'(1);
                    end
                end
                WRITE: begin
                    wrEn   <= 1'b1;
                    wrAddr <= dir_addr;
                    wrData <= $signed(mean);
                    if (mean_sat) overflow <= 1'b1;
                    if (dir_addr != '1) begin
                        dir_addr <= dir_addr + ADDR_WIDTH'(1);
                        acc      <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
